// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with burst locking.
// A grant covers up to max(weight,1) bursts. A burst ends on a beat carrying
// last and is never interrupted. On release the next requester after the
// current grantee takes over on the same edge. If there is no other requester,
// the arbiter returns to IDLE for one cycle. gnt_o, gnt_id_o and gnt_valid_o
// are registered, so they can drive a mux select directly.
module arbiter_wrr #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    last_i,
  input  logic [N*WW-1:0] weight_i,
  input  logic            ready_i,
  output logic [N-1:0]    gnt_o,
  output logic [IW-1:0]   gnt_id_o,
  output logic            gnt_valid_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] cred_q, cred_d;
  logic          inburst_q, inburst_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;

  logic [N-1:0]  cand_s;
  logic          win_found_s;
  logic [IW-1:0] win_idx_s;
  logic          req_g_s;
  logic          last_g_s;
  logic          beat_s;
  logic          release_s;
  logic          take_win_s;
  logic          go_idle_s;

  // One-hot vector with bit idx set.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Extra bursts remaining after the first: max(w,1)-1, so a weight of 0 acts as 1.
  function automatic logic [WW-1:0] first_credit(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    if (w == '0) begin
      r = '0;
    end else begin
      r = w - WW'(1);
    end
    return r;
  endfunction

  // The grantee's own request, last flag and beat qualifier.
  always_comb begin
    req_g_s  = req_i[ptr_q];
    last_g_s = last_i[ptr_q];
    beat_s   = (state_q == ST_GRANT) && req_g_s && ready_i && gnt_q[ptr_q];
  end

  // Find the first candidate after ptr_q, wrapping modulo N. While granted, the current grantee is masked off.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    if (state_q == ST_GRANT) begin
      cand_s = req_i & ~onehot(ptr_q);
    end else begin
      cand_s = req_i;
    end
    for (int k = 1; k <= N; k++) begin
      if (!win_found_s && cand_s[(int'(ptr_q) + k) % N]) begin
        win_found_s = 1'b1;
        win_idx_s   = IW'((int'(ptr_q) + k) % N);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic: burst tracking, credit use, release and handover.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cred_d      = cred_q;
    inburst_d   = inburst_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    release_s   = 1'b0;
    take_win_s  = 1'b0;
    go_idle_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          take_win_s = 1'b1;
        end else begin
          go_idle_s = 1'b1;
        end
      end
      ST_GRANT: begin
        if (beat_s && last_g_s) begin
          inburst_d = 1'b0;
          if (cred_q == '0) begin
            release_s = 1'b1;
          end else begin
            cred_d = cred_q - WW'(1);
          end
        end else if (beat_s) begin
          inburst_d = 1'b1;
        end else if (!req_g_s && !inburst_q) begin
          // Withdrawal between bursts gives up the remaining credit.
          release_s = 1'b1;
        end else begin
          // A ready stall, or a withdrawal inside a locked burst, holds the grant.
          inburst_d = inburst_q;
        end
        if (release_s && win_found_s) begin
          take_win_s = 1'b1;
        end else if (release_s) begin
          go_idle_s = 1'b1;
        end else begin
          take_win_s = 1'b0;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase

    if (take_win_s) begin
      state_d   = ST_GRANT;
      ptr_d     = win_idx_s;
      gnt_d     = onehot(win_idx_s);
      gnt_id_d  = win_idx_s;
      cred_d    = first_credit(weight_i[int'(win_idx_s)*WW +: WW]);
      inburst_d = 1'b0;
    end else if (go_idle_s) begin
      state_d   = ST_IDLE;
      gnt_d     = '0;
      gnt_id_d  = '0;
      cred_d    = '0;
      inburst_d = 1'b0;
    end else begin
      state_d = state_q;
    end

    gnt_valid_d = |gnt_d;
  end

  // State and output registers. Reset parks ptr at N-1, so index 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IW'(N - 1);
      cred_q      <= '0;
      inburst_q   <= 1'b0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cred_q      <= cred_d;
      inburst_q   <= inburst_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule
